// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4 master for the load/store unit: one pipeline request
// becomes one single-beat AXI read or write, with an extended/registered response.
module lsu_axi_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ID_VAL = 0
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ID_W-1:0]       M_AXI_ARID,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [ID_W-1:0]       M_AXI_AWID,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  output logic                  M_AXI_WLAST,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                req_ready_q, req_ready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                misaligned, aw_fin, w_fin;
  logic                unused_resp_lsb;

  assign unused_resp_lsb = M_AXI_RRESP[0] ^ M_AXI_BRESP[0];

  // Sign/zero extension of the low-aligned read beat.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] sz, input logic uns);
    logic [DATA_W-1:0] r;
    r = d;
    case (sz)
      2'd0:    r = {{(DATA_W-8){~uns & d[7]}}, d[7:0]};
      2'd1:    r = {{(DATA_W-16){~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    logic [STRB_W-1:0] m;
    case (sz)
      2'd0:    m = STRB_W'(4'b0001);
      2'd1:    m = STRB_W'(4'b0011);
      default: m = STRB_W'(4'b1111);
    endcase
    return m;
  endfunction

  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    size_d       = size_q;
    uns_d        = uns_q;
    req_ready_d  = req_ready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    aw_fin       = aw_done_q | (awvalid_q & M_AXI_AWREADY);
    w_fin        = w_done_q | (wvalid_q & M_AXI_WREADY);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          size_d      = req_size;
          uns_d       = req_unsigned;
          strb_d      = size_mask(req_size);
          req_ready_d = 1'b0;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_wen) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_d      = S_RESP;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = M_AXI_RRESP[1];
          resp_rdata_d = M_AXI_RRESP[1] ? '0 : extend(M_AXI_RDATA, size_q, uns_q);
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; B is only accepted once both have.
        if (aw_fin) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fin) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_d      = S_RESP;
          bready_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = M_AXI_BRESP[1];
          resp_rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = ID_W'(ID_VAL);
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = {1'b0, size_q};
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWID    = ID_W'(ID_VAL);
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = {1'b0, size_q};
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = strb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WLAST   = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Randomized bench for lsu_axi_master: a delay-programmable AXI slave plus a
// transaction-level model of the expected pipeline response and AXI beats.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wvalid, wlast, wready, bvalid, bready;
  logic [3:0]  arid, awid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_ARID(arid), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_AWID(awid), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Slave configuration and observations
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [31:0] sl_rdata;
  logic [1:0]  sl_rresp, sl_bresp;
  int          ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int          cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [7:0]  got_arlen;
  logic [2:0]  got_arsize;
  logic [31:0] got_wdata;
  logic [3:0]  got_wstrb;

  // Current transaction as seen by the model
  logic        cur_valid, cur_wen, cur_ill, exp_err;
  logic [31:0] cur_addr, cur_wdata, exp_rdata;
  logic [1:0]  cur_size;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] strb_of(input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Response a request must produce, from access rules and the slave's answer.
  task automatic model(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                       input logic [1:0] br, output logic ill, output logic err,
                       output logic [31:0] data);
    longint nbytes, span, v;
    nbytes = longint'(1) << size;
    ill = (size == 2'd3) || ((longint'(addr) % nbytes) != 0);
    data = 32'd0;
    if (ill) err = 1'b1;
    else if (wen) err = br[1];
    else if (rr[1]) err = 1'b1;
    else begin
      err = 1'b0;
      span = longint'(1) << (8 * nbytes);
      v = longint'(rd) % span;
      if (!uns && size != 2'd2 && v >= span / 2) v = v - span;
      data = 32'(v);
    end
  endtask

  // AXI slave: readiness/response timing follows the *_dly knobs.
  initial begin
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        if (arvalid && arready) begin
          ar_hs++; r_pend = 1; r_cnt = 0; got_arlen = arlen; got_arsize = arsize;
        end
        if (rvalid && rready) begin r_hs++; r_pend = 0; end
        if (awvalid && awready) begin aw_hs++; aw_got = 1; aw_cyc = cyc; end
        if (wvalid && wready) begin
          w_hs++; w_got = 1; w_cyc = cyc; got_wdata = wdata; got_wstrb = wstrb;
        end
        if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
        if (bvalid && bready) begin b_hs++; b_pend = 0; end
      end
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        arready = arvalid && (ar_cnt >= ar_dly); ar_cnt = arvalid ? ar_cnt + 1 : 0;
        awready = awvalid && (aw_cnt >= aw_dly); aw_cnt = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && (w_cnt >= w_dly);    w_cnt  = wvalid ? w_cnt + 1 : 0;
        if (r_pend) begin
          rdata = sl_rdata; rresp = sl_rresp;
          if (r_cnt >= r_dly) rvalid = 1; else r_cnt++;
        end else rvalid = 0;
        if (b_pend) begin
          bresp = sl_bresp;
          if (b_cnt >= b_dly) bvalid = 1; else b_cnt++;
        end else bvalid = 0;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the current model transaction.
  task automatic monitor();
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rst_req_ready", req_ready, 1);
        chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
        chk("rst_resp", {resp_err, resp_rdata}, 0);
        chk("rst_latches", {araddr, wdata}, 0);
      end else if (!cur_valid) begin
        chk("idle_valids", {arvalid, awvalid, wvalid, resp_valid}, 0);
      end else begin
        if (arvalid) begin
          chk("ar_fields", {araddr, arsize, arlen, arburst, arid},
              {cur_addr, 1'b0, cur_size, 8'd0, 2'b01, 4'd0});
          chk("ar_legal", cur_wen | cur_ill, 0);
        end
        if (awvalid) begin
          chk("aw_fields", {awaddr, awsize, awlen, awburst, awid},
              {cur_addr, 1'b0, cur_size, 8'd0, 2'b01, 4'd0});
          chk("aw_legal", !cur_wen | cur_ill, 0);
        end
        if (wvalid) chk("w_fields", {wdata, wstrb, wlast}, {cur_wdata, strb_of(cur_size), 1'b1});
        if (resp_valid) begin
          chk("resp", {resp_err, resp_rdata}, {exp_err, exp_rdata});
          chk("resp_req_ready", req_ready, 0);
        end
        if (cur_ill) chk("ill_no_axi", {arvalid, awvalid, wvalid}, 0);
      end
    end
  endtask

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] size, input logic uns, input logic [31:0] rd,
                        input logic [1:0] rr, input logic [1:0] br, input int hold,
                        output logic [31:0] g_rdata, output logic g_err, output int lat);
    int ar0, r0, aw0, w0, b0, n;
    logic ill, ee, acc;
    logic [31:0] ed;
    model(wen, addr, size, uns, rd, rr, br, ill, ee, ed);
    sl_rdata = rd; sl_rresp = rr; sl_bresp = br;
    cur_wen = wen; cur_addr = addr; cur_wdata = wd; cur_size = size; cur_ill = ill;
    exp_err = ee; exp_rdata = ed; cur_valid = 1;
    ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    g_rdata = 0; g_err = 0; lat = 0;
    req_wen = wen; req_addr = addr; req_wdata = wd; req_size = size; req_unsigned = uns;
    req_valid = 1;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(posedge clk);
      if (req_ready) acc = 1;
      n++;
    end
    @(negedge clk);
    req_valid = 0;
    req_addr = $urandom; req_wdata = $urandom; req_wen = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    if (!acc) begin chk("accept_timeout", 0, 1); return; end
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!resp_valid) begin chk("resp_timeout", 0, 1); return; end
    g_rdata = resp_rdata; g_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {resp_valid, req_ready}, 2'b10);
      chk("hold_data", {resp_err, resp_rdata}, {g_err, g_rdata});
    end
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 0;
    chk("resp_done", {resp_valid, req_ready}, 2'b01);
    chk("hs_counts", {8'(ar_hs - ar0), 8'(r_hs - r0), 8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)},
        {8'(!ill && !wen), 8'(!ill && !wen), 8'(!ill && wen), 8'(!ill && wen), 8'(!ill && wen)});
  endtask

  initial begin
    logic [31:0] gd, a;
    logic        ge, w, u;
    logic [1:0]  sz;
    int          lat, r0, n;
    rst_n = 0; cur_valid = 0;
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0;
    req_unsigned = 0; resp_ready = 0;
    cur_wen = 0; cur_ill = 0; cur_addr = 0; cur_wdata = 0; cur_size = 0;
    exp_err = 0; exp_rdata = 0;
    sl_rdata = 0; sl_rresp = 0; sl_bresp = 0;
    set_dly(0, 0, 0, 0, 0);
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Word load, zero-wait slave
    do_txn(0, 32'h8000_0004, 0, 2, 0, 32'hDEAD_BEEF, 2'b01, 0, 0, gd, ge, lat);
    chk("t1_rdata", gd, 32'hDEAD_BEEF);
    chk("t1_err", ge, 0);
    chk("t1_latency", lat, 3);
    chk("t1_ar", {got_arlen, got_arsize}, {8'd0, 3'd2});

    // Signed and unsigned byte load
    do_txn(0, 32'h8000_0003, 0, 0, 0, 32'h0000_0080, 2'b00, 0, 0, gd, ge, lat);
    chk("t2_signed", gd, 32'hFFFF_FF80);
    do_txn(0, 32'h8000_0003, 0, 0, 1, 32'h0000_0080, 2'b00, 0, 0, gd, ge, lat);
    chk("t2_unsigned", gd, 32'h0000_0080);

    // Half store with AW accepted 3 cycles after W
    set_dly(0, 0, 3, 0, 0);
    do_txn(1, 32'h8000_0002, 32'h0000_1234, 1, 0, 0, 0, 2'b00, 0, gd, ge, lat);
    chk("t3_err", {ge, gd}, 0);
    chk("t3_w", {got_wstrb, got_wdata}, {4'b0011, 32'h0000_1234});
    chk("t3_w_before_aw", aw_cyc - w_cyc, 3);
    set_dly(0, 0, 0, 0, 0);

    // Misaligned word store
    do_txn(1, 32'h8000_0001, 32'hCAFE_F00D, 2, 0, 0, 0, 2'b00, 0, gd, ge, lat);
    chk("t4_err", ge, 1);
    chk("t4_latency", lat, 1);

    // Error load held 5 cycles
    do_txn(0, 32'h8000_0010, 0, 2, 0, 32'h1234_5678, 2'b10, 0, 5, gd, ge, lat);
    chk("t5_resp", {ge, gd}, {1'b1, 32'h0});

    // Reset while waiting for R
    set_dly(0, 20, 0, 0, 0);
    sl_rdata = 32'h5555_AAAA; sl_rresp = 0;
    cur_wen = 0; cur_addr = 32'h0000_0100; cur_size = 2; cur_ill = 0;
    exp_err = 0; exp_rdata = 32'h5555_AAAA; cur_valid = 1;
    req_wen = 0; req_addr = 32'h0000_0100; req_size = 2; req_valid = 1;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); req_valid = 0; n++; end
    chk("t6_in_rd_data", rready, 1);
    req_valid = 0;
    r0 = r_hs;
    rst_n = 0; cur_valid = 0;
    #1;
    chk("t6_async_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid}, 0);
    chk("t6_async_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_resp", resp_valid, 0);
    end
    chk("t6_no_r_hs", r_hs - r0, 0);
    set_dly(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_txn(w, a, $urandom, sz, u, $urandom, 2'($urandom), 2'($urandom),
             $urandom_range(0, 2), gd, ge, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI4 master for the load/store unit. It sits directly upstream of the data SRAM AXI slave. It turns one pipeline load/store request into a single-beat AXI read (AR/R) or write (AW/W/B) transaction. It returns sign/zero-extended load data or write completion to the pipeline. At most one transaction is outstanding.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width; strobe width is DATA_W/8
ID_W  4  AXI ID width
ID_VAL  0  constant ID driven on ARID/AWID

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  reset, asynchronous, active-low
req_valid  in  1  pipeline request valid
req_ready  out  1  block idle, request accepted when both high
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, low-aligned
req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
req_unsigned  in  1  load zero-extends when 1
resp_valid  out  1  response valid
resp_ready  in  1  pipeline accepts response
resp_rdata  out  DATA_W  extended load data (0 for stores/errors)
resp_err  out  1  misaligned/illegal size or AXI error response
M_AXI_ARADDR  out  ADDR_W  latched req_addr
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_ARID  out  ID_W  ID_VAL
M_AXI_ARLEN  out  8  constant 0
M_AXI_ARSIZE  out  3  {1'b0, latched size}
M_AXI_ARBURST  out  2  constant 2'b01
M_AXI_RDATA  in  DATA_W  read data, low-aligned
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXI_AWADDR  out  ADDR_W  latched req_addr
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_AWID  out  ID_W  ID_VAL
M_AXI_AWLEN  out  8  constant 0
M_AXI_AWSIZE  out  3  {1'b0, latched size}
M_AXI_AWBURST  out  2  constant 2'b01
M_AXI_WDATA  out  DATA_W  latched req_wdata, unshifted
M_AXI_WSTRB  out  DATA_W/8  size mask, unshifted: 0001/0011/1111
M_AXI_WVALID  out  1  write data valid
M_AXI_WLAST  out  1  equals WVALID
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- Reset (async, ARESETN low): state IDLE. All VALID/READY outputs 0, except req_ready = 1. resp_rdata = 0, resp_err = 0, address/data latches 0.
- Reset asserted mid-transaction: transaction is abandoned with no response.
- req_ready = (state == IDLE). On req_valid&&req_ready, latch addr, wdata, size, wen, unsigned.
- Misaligned (half with addr[0]; word with addr[1:0] != 0) or size 3: no AXI activity. Next state RESP with resp_err = 1 and rdata = 0.
- Load: RD_ADDR drives ARVALID = 1 until ARREADY is sampled high. ARADDR is held stable meanwhile. Then RD_DATA with RREADY = 1.
- On RVALID: resp_rdata = RDATA[7:0] or [15:0], zero- or sign-extended (word passes through). resp_err = RRESP[1]. Go to RESP.
- Store: WR_REQ asserts AWVALID and WVALID in the same cycle. Each drops independently after its own handshake (aw_done/w_done flags), and either may complete first or both together. When both are done, go to WR_RESP with BREADY = 1.
- On BVALID: resp_err = BRESP[1], rdata = 0, go to RESP.
- RESP: resp_valid = 1, data held stable until resp_ready. Then IDLE, with the earliest next request one cycle later.
- Idle-to-AR/AW latency is 1 cycle. Minimum load turnaround is 4 cycles with a zero-wait slave.

Test Plan:
- Load word at 0x8000_0004, RDATA 0xDEAD_BEEF, RRESP 01 -> one AR (ARLEN 0, ARSIZE 2), resp_rdata 0xDEAD_BEEF, resp_err 0.
- Load byte signed at 0x8000_0003, RDATA 0x0000_0080 -> 0xFFFF_FF80; same request unsigned -> 0x0000_0080.
- Store half 0x1234 at 0x8000_0002 with AWREADY delayed 3 cycles after WREADY -> WSTRB 0011, WDATA 0x0000_1234, WVALID drops before AWVALID, single B handshake, resp_err 0.
- Store word at 0x8000_0001 -> no AWVALID/WVALID ever, resp_valid with resp_err 1 next cycle.
- Load with RRESP 2'b10 and resp_ready held low 5 cycles -> resp_err 1, resp_valid and data stable 5 cycles, req_ready 0 throughout.
- ARESETN low while in RD_DATA -> all VALIDs 0 immediately, req_ready 1, no response after release.
